// File: rtl/tl_test_pkg.sv
// TileLink A-channel opcodes, arbiter state encoding and beat-count helpers.
package tl_test_pkg;

    typedef enum logic [2:0] {
        TL_A_PUT_FULL_DATA    = 3'd0,
        TL_A_PUT_PARTIAL_DATA = 3'd1,
        TL_A_ARITHMETIC_DATA  = 3'd2,
        TL_A_LOGICAL_DATA     = 3'd3,
        TL_A_GET              = 3'd4,
        TL_A_INTENT           = 3'd5,
        TL_A_ACQUIRE_BLOCK    = 3'd6,
        TL_A_ACQUIRE_PERM     = 3'd7
    } tl_a_opcode_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic a_has_data(input logic [2:0] opcode);
        return (opcode == TL_A_PUT_FULL_DATA)    ||
               (opcode == TL_A_PUT_PARTIAL_DATA) ||
               (opcode == TL_A_ARITHMETIC_DATA)  ||
               (opcode == TL_A_LOGICAL_DATA);
    endfunction

    // Beats in a message: data-less opcodes and sub-beat sizes always take one beat.
    function automatic int unsigned tl_beats(input int unsigned size,
                                             input logic [2:0]  opcode,
                                             input int unsigned data_wd);
        int unsigned lg;
        lg = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if ((32'd1 << i) == (data_wd / 8)) lg = i;
        end
        if (!a_has_data(opcode) || (size <= lg)) return 1;
        return 32'd1 << (size - lg);
    endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, circularly.
module tl_rr_picker
    import tl_test_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_WD  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_WD-1:0]  ptr_i,
    output logic [NUM_REQ-1:0] sel_oh_o,
    output logic [IDX_WD-1:0]  sel_idx_o,
    output logic               any_o
);

    int unsigned       cand;
    logic [IDX_WD-1:0] cand_idx;
    logic              found;

    always_comb begin
        sel_oh_o  = '0;
        sel_idx_o = '0;
        cand      = 0;
        cand_idx  = '0;
        found     = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_WD'(cand);
            if (!found && req_i[cand_idx]) begin
                found              = 1'b1;
                sel_idx_o          = cand_idx;
                sel_oh_o[cand_idx] = 1'b1;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/tl_a_arbiter.sv
// Round-robin TileLink A-channel arbiter with multi-beat message lock and tag-steered D return.
module tl_a_arbiter
    import tl_test_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned SIZE_WD   = 3,
    parameter  int unsigned ADDR_WD   = 36,
    parameter  int unsigned DATA_WD   = 256,
    parameter  int unsigned SOURCE_WD = 8,
    parameter  int unsigned SINK_WD   = 32,
    localparam int unsigned IDX_WD    = $clog2(NUM_REQ),
    localparam int unsigned MASK_WD   = DATA_WD / 8
) (
    input  logic                           clock,
    input  logic                           reset_n,

    input  logic [NUM_REQ-1:0]             in_a_valid,
    output logic [NUM_REQ-1:0]             in_a_ready,
    input  logic [NUM_REQ*3-1:0]           in_a_opcode,
    input  logic [NUM_REQ*3-1:0]           in_a_param,
    input  logic [NUM_REQ*SIZE_WD-1:0]     in_a_size,
    input  logic [NUM_REQ*SOURCE_WD-1:0]   in_a_source,
    input  logic [NUM_REQ*ADDR_WD-1:0]     in_a_address,
    input  logic [NUM_REQ*MASK_WD-1:0]     in_a_mask,
    input  logic [NUM_REQ*DATA_WD-1:0]     in_a_data,

    output logic                           out_a_valid,
    input  logic                           out_a_ready,
    output logic [2:0]                     out_a_opcode,
    output logic [2:0]                     out_a_param,
    output logic [SIZE_WD-1:0]             out_a_size,
    output logic [SOURCE_WD+IDX_WD-1:0]    out_a_source,
    output logic [ADDR_WD-1:0]             out_a_address,
    output logic [MASK_WD-1:0]             out_a_mask,
    output logic [DATA_WD-1:0]             out_a_data,

    input  logic                           out_d_valid,
    output logic                           out_d_ready,
    input  logic [2:0]                     out_d_opcode,
    input  logic [1:0]                     out_d_param,
    input  logic [SIZE_WD-1:0]             out_d_size,
    input  logic [SOURCE_WD+IDX_WD-1:0]    out_d_source,
    input  logic [SINK_WD-1:0]             out_d_sink,
    input  logic                           out_d_denied,
    input  logic                           out_d_corrupt,
    input  logic [DATA_WD-1:0]             out_d_data,

    output logic [NUM_REQ-1:0]             in_d_valid,
    input  logic [NUM_REQ-1:0]             in_d_ready,
    output logic [2:0]                     in_d_opcode,
    output logic [1:0]                     in_d_param,
    output logic [SIZE_WD-1:0]             in_d_size,
    output logic [SOURCE_WD-1:0]           in_d_source,
    output logic [SINK_WD-1:0]             in_d_sink,
    output logic                           in_d_denied,
    output logic                           in_d_corrupt,
    output logic [DATA_WD-1:0]             in_d_data,

    output logic                           route_err
);

    localparam int unsigned MAX_SIZE = (1 << SIZE_WD) - 1;
    localparam int unsigned LOG_BEAT = $clog2(MASK_WD);
    localparam int unsigned CNT_WD   = (MAX_SIZE >= LOG_BEAT) ? (MAX_SIZE - LOG_BEAT + 1) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_WD-1:0] grant_q, grant_d;
    logic [IDX_WD-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_WD-1:0] beats_left_q, beats_left_d;
    logic              route_err_q, route_err_d;

    logic [2:0]           a_opcode  [NUM_REQ];
    logic [2:0]           a_param   [NUM_REQ];
    logic [SIZE_WD-1:0]   a_size    [NUM_REQ];
    logic [SOURCE_WD-1:0] a_source  [NUM_REQ];
    logic [ADDR_WD-1:0]   a_address [NUM_REQ];
    logic [MASK_WD-1:0]   a_mask    [NUM_REQ];
    logic [DATA_WD-1:0]   a_data    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_opcode[g]  = in_a_opcode[g*3 +: 3];
        assign a_param[g]   = in_a_param[g*3 +: 3];
        assign a_size[g]    = in_a_size[g*SIZE_WD +: SIZE_WD];
        assign a_source[g]  = in_a_source[g*SOURCE_WD +: SOURCE_WD];
        assign a_address[g] = in_a_address[g*ADDR_WD +: ADDR_WD];
        assign a_mask[g]    = in_a_mask[g*MASK_WD +: MASK_WD];
        assign a_data[g]    = in_a_data[g*DATA_WD +: DATA_WD];
    end

    logic [NUM_REQ-1:0] sel_oh;
    logic [IDX_WD-1:0]  sel_idx;
    logic               any_valid;

    tl_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i     (in_a_valid),
        .ptr_i     (rr_ptr_q),
        .sel_oh_o  (sel_oh),
        .sel_idx_o (sel_idx),
        .any_o     (any_valid)
    );

    logic [IDX_WD-1:0]  mux_idx;
    logic [NUM_REQ-1:0] mux_oh;
    logic               a_valid;
    logic               a_fire;
    logic [CNT_WD-1:0]  msg_beats;

    // Fresh pick while idle; pinned to the granted requester while locked.
    always_comb begin
        mux_idx = sel_idx;
        mux_oh  = sel_oh;
        a_valid = any_valid;
        if (state_q == ARB_LOCKED) begin
            mux_idx = grant_q;
            mux_oh  = NUM_REQ'(1) << grant_q;
            a_valid = in_a_valid[grant_q];
        end
    end

    assign out_a_opcode  = a_opcode[mux_idx];
    assign out_a_param   = a_param[mux_idx];
    assign out_a_size    = a_size[mux_idx];
    assign out_a_source  = {mux_idx, a_source[mux_idx]};
    assign out_a_address = a_address[mux_idx];
    assign out_a_mask    = a_mask[mux_idx];
    assign out_a_data    = a_data[mux_idx];
    assign out_a_valid   = a_valid & reset_n;
    assign in_a_ready    = mux_oh & {NUM_REQ{out_a_ready & reset_n}};

    assign a_fire    = a_valid & out_a_ready;
    assign msg_beats = CNT_WD'(tl_beats(32'(out_a_size), out_a_opcode, DATA_WD));

    function automatic logic [IDX_WD-1:0] next_idx(input logic [IDX_WD-1:0] idx);
        return (32'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_WD'(1);
    endfunction

    // A stalled first beat also locks, so the offered payload cannot change under backpressure.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beats_left_d = beats_left_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid) begin
                    if (!out_a_ready) begin
                        state_d      = ARB_LOCKED;
                        grant_d      = sel_idx;
                        beats_left_d = msg_beats;
                    end else if (msg_beats == CNT_WD'(1)) begin
                        rr_ptr_d = next_idx(sel_idx);
                    end else begin
                        state_d      = ARB_LOCKED;
                        grant_d      = sel_idx;
                        beats_left_d = msg_beats - CNT_WD'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                if (a_fire) begin
                    if (beats_left_q == CNT_WD'(1)) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_idx(grant_q);
                    end else begin
                        beats_left_d = beats_left_q - CNT_WD'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    logic [IDX_WD-1:0] d_tag;
    logic              d_tag_ok;

    assign d_tag    = out_d_source[SOURCE_WD +: IDX_WD];
    assign d_tag_ok = (32'(d_tag) < NUM_REQ);

    // Unknown tags are sunk so a stray response cannot wedge the D channel.
    assign in_d_valid  = (d_tag_ok && out_d_valid && reset_n) ? (NUM_REQ'(1) << d_tag) : '0;
    assign out_d_ready = reset_n & (d_tag_ok ? in_d_ready[d_tag] : 1'b1);
    assign route_err_d = route_err_q | (out_d_valid & ~d_tag_ok);
    assign route_err   = route_err_q;

    assign in_d_opcode  = out_d_opcode;
    assign in_d_param   = out_d_param;
    assign in_d_size    = out_d_size;
    assign in_d_source  = out_d_source[SOURCE_WD-1:0];
    assign in_d_sink    = out_d_sink;
    assign in_d_denied  = out_d_denied;
    assign in_d_corrupt = out_d_corrupt;
    assign in_d_data    = out_d_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beats_left_q <= '0;
            route_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
            route_err_q  <= route_err_d;
        end
    end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Directed bench for tl_a_arbiter: vector table for arbitration plus reset, backpressure and D-routing sequences.
module tb_tl_a_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned SW  = 3;
    localparam int unsigned AW  = 36;
    localparam int unsigned DW  = 256;
    localparam int unsigned SRW = 8;
    localparam int unsigned SKW = 32;
    localparam int unsigned MW  = DW / 8;
    localparam int unsigned N3  = 3;

    logic clk;
    logic rst_n;

    // main DUT, NUM_REQ = 4
    logic [N-1:0]      in_a_valid, in_a_ready;
    logic [N*3-1:0]    in_a_opcode, in_a_param;
    logic [N*SW-1:0]   in_a_size;
    logic [N*SRW-1:0]  in_a_source;
    logic [N*AW-1:0]   in_a_address;
    logic [N*MW-1:0]   in_a_mask;
    logic [N*DW-1:0]   in_a_data;
    logic              out_a_valid, out_a_ready;
    logic [2:0]        out_a_opcode, out_a_param;
    logic [SW-1:0]     out_a_size;
    logic [SRW+1:0]    out_a_source;
    logic [AW-1:0]     out_a_address;
    logic [MW-1:0]     out_a_mask;
    logic [DW-1:0]     out_a_data;
    logic              out_d_valid, out_d_ready;
    logic [2:0]        out_d_opcode;
    logic [1:0]        out_d_param;
    logic [SW-1:0]     out_d_size;
    logic [SRW+1:0]    out_d_source;
    logic [SKW-1:0]    out_d_sink;
    logic              out_d_denied, out_d_corrupt;
    logic [DW-1:0]     out_d_data;
    logic [N-1:0]      in_d_valid, in_d_ready;
    logic [2:0]        in_d_opcode;
    logic [1:0]        in_d_param;
    logic [SW-1:0]     in_d_size;
    logic [SRW-1:0]    in_d_source;
    logic [SKW-1:0]    in_d_sink;
    logic              in_d_denied, in_d_corrupt;
    logic [DW-1:0]     in_d_data;
    logic              route_err;

    // second DUT, NUM_REQ = 3, used for out-of-range tags
    logic [N3-1:0]     t3_a_valid, t3_a_ready;
    logic [N3*3-1:0]   t3_a_opcode, t3_a_param;
    logic [N3*SW-1:0]  t3_a_size;
    logic [N3*SRW-1:0] t3_a_source;
    logic [N3*AW-1:0]  t3_a_address;
    logic [N3*MW-1:0]  t3_a_mask;
    logic [N3*DW-1:0]  t3_a_data;
    logic              t3_oa_valid;
    logic [2:0]        t3_oa_opcode, t3_oa_param;
    logic [SW-1:0]     t3_oa_size;
    logic [SRW+1:0]    t3_oa_source;
    logic [AW-1:0]     t3_oa_address;
    logic [MW-1:0]     t3_oa_mask;
    logic [DW-1:0]     t3_oa_data;
    logic              t3_od_valid, t3_od_ready;
    logic [SRW+1:0]    t3_od_source;
    logic [N3-1:0]     t3_d_valid, t3_d_ready;
    logic [2:0]        t3_d_opcode;
    logic [1:0]        t3_d_param;
    logic [SW-1:0]     t3_d_size;
    logic [SRW-1:0]    t3_d_source;
    logic [SKW-1:0]    t3_d_sink;
    logic              t3_d_denied, t3_d_corrupt;
    logic [DW-1:0]     t3_d_data;
    logic              t3_route_err;

    tl_a_arbiter #(.NUM_REQ(N)) dut (
        .clock(clk), .reset_n(rst_n),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
        .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
        .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
        .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
        .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
        .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
        .out_d_data(out_d_data),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
        .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
        .in_d_sink(in_d_sink), .in_d_denied(in_d_denied), .in_d_corrupt(in_d_corrupt),
        .in_d_data(in_d_data), .route_err(route_err)
    );

    tl_a_arbiter #(.NUM_REQ(N3)) dut3 (
        .clock(clk), .reset_n(rst_n),
        .in_a_valid(t3_a_valid), .in_a_ready(t3_a_ready), .in_a_opcode(t3_a_opcode),
        .in_a_param(t3_a_param), .in_a_size(t3_a_size), .in_a_source(t3_a_source),
        .in_a_address(t3_a_address), .in_a_mask(t3_a_mask), .in_a_data(t3_a_data),
        .out_a_valid(t3_oa_valid), .out_a_ready(1'b0), .out_a_opcode(t3_oa_opcode),
        .out_a_param(t3_oa_param), .out_a_size(t3_oa_size), .out_a_source(t3_oa_source),
        .out_a_address(t3_oa_address), .out_a_mask(t3_oa_mask), .out_a_data(t3_oa_data),
        .out_d_valid(t3_od_valid), .out_d_ready(t3_od_ready), .out_d_opcode(3'd1),
        .out_d_param(2'd0), .out_d_size(3'd5), .out_d_source(t3_od_source),
        .out_d_sink(32'd0), .out_d_denied(1'b0), .out_d_corrupt(1'b0),
        .out_d_data(256'd0),
        .in_d_valid(t3_d_valid), .in_d_ready(t3_d_ready), .in_d_opcode(t3_d_opcode),
        .in_d_param(t3_d_param), .in_d_size(t3_d_size), .in_d_source(t3_d_source),
        .in_d_sink(t3_d_sink), .in_d_denied(t3_d_denied), .in_d_corrupt(t3_d_corrupt),
        .in_d_data(t3_d_data), .route_err(t3_route_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] op;
        logic [11:0] sz;
        logic        ordy;
        logic        ev;
        logic [1:0]  etag;
        logic [3:0]  erdy;
    } vec_t;

    vec_t vecs [23];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [11:0] GETS = 12'o4444;
    localparam logic [11:0] S3   = 12'o3333;

    function automatic vec_t mk(input logic [3:0] valid, input logic [11:0] op, input logic [11:0] sz,
                                input logic ordy, input logic ev, input logic [1:0] etag,
                                input logic [3:0] erdy);
        vec_t v;
        v.valid = valid; v.op = op; v.sz = sz; v.ordy = ordy;
        v.ev = ev; v.etag = etag; v.erdy = erdy;
        return v;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(64'h8_0000_0040 + 64'(i) * 64'h1000);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return {8{32'hD000_0000 + 32'(i)}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [3:0] valid, input logic [11:0] op, input logic [11:0] sz,
                           input logic ordy);
        in_a_valid  = valid;
        in_a_opcode = op;
        in_a_size   = sz;
        out_a_ready = ordy;
    endtask

    initial begin
        vecs[0]  = mk(4'b1111, GETS, S3, 1'b1, 1'b1, 2'd0, 4'b0001);
        vecs[1]  = mk(4'b1111, GETS, S3, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[2]  = mk(4'b1111, GETS, S3, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[3]  = mk(4'b1111, GETS, S3, 1'b1, 1'b1, 2'd3, 4'b1000);
        vecs[4]  = mk(4'b1111, GETS, S3, 1'b1, 1'b1, 2'd0, 4'b0001);
        vecs[5]  = mk(4'b0111, 12'o4404, 12'o3373, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[6]  = mk(4'b0111, 12'o4404, 12'o3373, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[7]  = mk(4'b0111, 12'o4404, 12'o3373, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[8]  = mk(4'b0111, 12'o4404, 12'o3373, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[9]  = mk(4'b0101, GETS, S3, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[10] = mk(4'b0101, GETS, S3, 1'b1, 1'b1, 2'd0, 4'b0001);
        vecs[11] = mk(4'b0000, GETS, S3, 1'b1, 1'b0, 2'd0, 4'b0000);
        vecs[12] = mk(4'b0010, GETS, S3, 1'b0, 1'b1, 2'd1, 4'b0000);
        vecs[13] = mk(4'b0011, GETS, S3, 1'b0, 1'b1, 2'd1, 4'b0000);
        vecs[14] = mk(4'b0011, GETS, S3, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[15] = mk(4'b0011, GETS, S3, 1'b1, 1'b1, 2'd0, 4'b0001);
        vecs[16] = mk(4'b0010, 12'o4404, 12'o3353, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[17] = mk(4'b0110, 12'o4404, 12'o3353, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[18] = mk(4'b0110, GETS, 12'o3373, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[19] = mk(4'b0110, GETS, 12'o3373, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[20] = mk(4'b0100, 12'o4244, 12'o3633, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[21] = mk(4'b0110, 12'o4244, 12'o3633, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[22] = mk(4'b0110, GETS, S3, 1'b1, 1'b1, 2'd1, 4'b0010);

        for (int i = 0; i < int'(N); i++) begin
            in_a_param[i*3 +: 3]     = 3'(i);
            in_a_source[i*SRW +: SRW] = 8'h10 + 8'(i);
            in_a_address[i*AW +: AW]  = addr_of(i);
            in_a_mask[i*MW +: MW]     = '1;
            in_a_data[i*DW +: DW]     = data_of(i);
        end
        t3_a_valid = '0; t3_a_opcode = '0; t3_a_param = '0; t3_a_size = '0;
        t3_a_source = '0; t3_a_address = '0; t3_a_mask = '0; t3_a_data = '0;
        t3_od_valid = 1'b0; t3_od_source = '0; t3_d_ready = '0;
        out_d_opcode = 3'd1; out_d_param = 2'd0; out_d_size = 3'd5; out_d_sink = 32'h1234_5678;
        out_d_denied = 1'b0; out_d_corrupt = 1'b1; out_d_data = {8{32'hCAFE_F00D}};

        // Reset holds every handshake output low even with all inputs active.
        rst_n = 1'b0;
        drive_a(4'b1111, GETS, S3, 1'b1);
        out_d_valid = 1'b1; out_d_source = {2'd0, 8'h01}; in_d_ready = 4'b1111;
        #3;
        chk("rst.out_a_valid", DW'(out_a_valid), DW'(0));
        chk("rst.in_a_ready", DW'(in_a_ready), DW'(0));
        chk("rst.out_d_ready", DW'(out_d_ready), DW'(0));
        chk("rst.in_d_valid", DW'(in_d_valid), DW'(0));
        chk("rst.route_err", DW'(route_err), DW'(0));
        drive_a(4'b0000, GETS, S3, 1'b0);
        out_d_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 23; k++) begin
            logic [11:0] opv;
            @(negedge clk);
            drive_a(vecs[k].valid, vecs[k].op, vecs[k].sz, vecs[k].ordy);
            #1;
            opv = vecs[k].op;
            chk($sformatf("v%0d.valid", k), DW'(out_a_valid), DW'(vecs[k].ev));
            chk($sformatf("v%0d.in_a_ready", k), DW'(in_a_ready), DW'(vecs[k].erdy));
            if (vecs[k].ev) begin
                chk($sformatf("v%0d.source", k), DW'(out_a_source),
                    DW'({vecs[k].etag, 8'h10 + 8'(vecs[k].etag)}));
                chk($sformatf("v%0d.opcode", k), DW'(out_a_opcode), DW'(opv[int'(vecs[k].etag)*3 +: 3]));
            end
        end

        // D steering by tag with tag stripped, concurrent with an idle A side.
        @(negedge clk);
        drive_a(4'b0000, GETS, S3, 1'b1);
        out_d_valid = 1'b1; out_d_source = {2'd2, 8'h5A}; in_d_ready = 4'b0100;
        #1;
        chk("d.in_d_valid", DW'(in_d_valid), DW'(4'b0100));
        chk("d.in_d_source", DW'(in_d_source), DW'(8'h5A));
        chk("d.out_d_ready_hi", DW'(out_d_ready), DW'(1));
        chk("d.in_d_data", in_d_data, {8{32'hCAFE_F00D}});
        chk("d.in_d_sink", DW'(in_d_sink), DW'(32'h1234_5678));
        in_d_ready = 4'b1011;
        #1;
        chk("d.out_d_ready_lo", DW'(out_d_ready), DW'(0));
        chk("d.in_d_valid_held", DW'(in_d_valid), DW'(4'b0100));
        out_d_valid = 1'b0;
        #1;
        chk("d.in_d_valid_idle", DW'(in_d_valid), DW'(0));

        // Out-of-range tag on the 3-requester instance.
        @(negedge clk);
        t3_od_valid = 1'b1; t3_od_source = {2'd3, 8'h77}; t3_d_ready = 3'b000;
        #1;
        chk("bad.out_d_ready", DW'(t3_od_ready), DW'(1));
        chk("bad.in_d_valid", DW'(t3_d_valid), DW'(0));
        chk("bad.route_err_pre", DW'(t3_route_err), DW'(0));
        @(negedge clk);
        t3_od_valid = 1'b0;
        #1;
        chk("bad.route_err_set", DW'(t3_route_err), DW'(1));
        @(negedge clk);
        t3_od_valid = 1'b1; t3_od_source = {2'd1, 8'h22}; t3_d_ready = 3'b010;
        #1;
        chk("bad.good_valid", DW'(t3_d_valid), DW'(3'b010));
        chk("bad.good_source", DW'(t3_d_source), DW'(8'h22));
        chk("bad.route_err_sticky", DW'(t3_route_err), DW'(1));
        t3_d_ready = 3'b000;
        #1;
        chk("bad.good_ready_lo", DW'(t3_od_ready), DW'(0));
        t3_od_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("bad.route_err_clr", DW'(t3_route_err), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure: req3 payload must stay put while req0 shows up.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive_a((c >= 2) ? 4'b1001 : 4'b1000, GETS, S3, (c == 5));
            #1;
            chk($sformatf("bp%0d.valid", c), DW'(out_a_valid), DW'(1));
            chk($sformatf("bp%0d.source", c), DW'(out_a_source), DW'({2'd3, 8'h13}));
            chk($sformatf("bp%0d.address", c), DW'(out_a_address), DW'(addr_of(3)));
            chk($sformatf("bp%0d.data", c), out_a_data, data_of(3));
            chk($sformatf("bp%0d.in_a_ready", c), DW'(in_a_ready), (c == 5) ? DW'(4'b1000) : DW'(0));
        end
        @(negedge clk);
        drive_a(4'b0001, GETS, S3, 1'b1);
        #1;
        chk("bp.next_source", DW'(out_a_source), DW'({2'd0, 8'h10}));

        // Reset during beat 2 of a 4-beat req1 PutFullData.
        @(negedge clk);
        drive_a(4'b0010, 12'o4404, 12'o3373, 1'b1);
        #1;
        chk("mid.beat1", DW'(out_a_source), DW'({2'd1, 8'h11}));
        @(negedge clk);
        #1;
        chk("mid.beat2", DW'(out_a_source), DW'({2'd1, 8'h11}));
        out_d_valid = 1'b1; out_d_source = {2'd0, 8'h01}; in_d_ready = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid.out_a_valid", DW'(out_a_valid), DW'(0));
        chk("mid.in_a_ready", DW'(in_a_ready), DW'(0));
        chk("mid.out_d_ready", DW'(out_d_ready), DW'(0));
        chk("mid.in_d_valid", DW'(in_d_valid), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        out_d_valid = 1'b0;
        drive_a(4'b0011, GETS, S3, 1'b1);
        #1;
        chk("mid.after_source", DW'(out_a_source), DW'({2'd0, 8'h10}));
        chk("mid.after_ready", DW'(in_a_ready), DW'(4'b0001));
        @(negedge clk);
        drive_a(4'b0010, GETS, S3, 1'b1);
        #1;
        chk("mid.after_next", DW'(out_a_source), DW'({2'd1, 8'h11}));
        chk("route_err_main", DW'(route_err), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tl_a_arbiter.md
Name: tl_a_arbiter

Overview:
- Shares one TileLink A channel between NUM_REQ requesters (DMA, tile and test agents) and routes the D channel back to the right requester.
- Arbitration is round-robin with a message lock: a multi-beat PutFullData, PutPartialData, ArithmeticData or LogicalData is never interleaved with another requester's beats.
- Outgoing a_source is tagged with the requester index in its upper bits. D responses are steered by that tag, and the tag is stripped before delivery.
- Sits in the tl-test DUT environment between the agents and the L2/L3 slave port; the existing tl_monitor instances attach to its out_* side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIZE_WD, 3, a_size/d_size width (log2 bytes).
- ADDR_WD, 36, address width.
- DATA_WD, 256, beat data width; beat bytes = DATA_WD/8.
- SOURCE_WD, 8, per-requester source width.
- SINK_WD, 32, d_sink width.
- IDX_WD, $clog2(NUM_REQ), requester tag width (derived).

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_a_valid/in_a_ready  in/out  NUM_REQ  per-requester A handshake.
- in_a_opcode  in  NUM_REQ*3  packed, requester i at [i*3+:3]; the other in_a_* fields pack the same way.
- in_a_param  in  NUM_REQ*3.
- in_a_size  in  NUM_REQ*SIZE_WD.
- in_a_source  in  NUM_REQ*SOURCE_WD.
- in_a_address  in  NUM_REQ*ADDR_WD.
- in_a_mask  in  NUM_REQ*DATA_WD/8.
- in_a_data  in  NUM_REQ*DATA_WD.
- out_a_valid/out_a_ready  out/in  1.
- out_a_opcode, out_a_param, out_a_size, out_a_address, out_a_mask, out_a_data  out  matching widths.
- out_a_source  out  SOURCE_WD+IDX_WD  {requester index, in_a_source}.
- out_d_valid/out_d_ready  in/out  1.
- out_d_opcode 3, out_d_param 2, out_d_size SIZE_WD, out_d_sink SINK_WD, out_d_denied 1, out_d_corrupt 1, out_d_data DATA_WD  in.
- out_d_source  in  SOURCE_WD+IDX_WD.
- in_d_valid/in_d_ready  out/in  NUM_REQ.
- in_d_opcode, param, size, sink, denied, corrupt, data  out  broadcast, single copy.
- in_d_source  out  SOURCE_WD  out_d_source with the tag stripped.
- route_err  out  1  sticky: a D beat arrived with tag >= NUM_REQ.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State cleared: locked=0, grant=0, rr_ptr=0, beats_left=0, route_err=0.
  - While reset_n=0, the outputs out_a_valid, in_a_ready, out_d_ready and in_d_valid are forced to 0.
- Beat count:
  - beats(size) = 1 when size <= log2(DATA_WD/8) or the opcode carries no data (Get=4, Intent=5, AcquireBlock=6, AcquirePerm=7).
  - Otherwise beats = 2^(size - log2(DATA_WD/8)).
  - Counter width is enough for 2^SIZE_WD-byte messages.
- States: IDLE (locked=0) and LOCKED (locked=1).
- IDLE:
  - sel = first i with in_a_valid[i], searching circularly from rr_ptr.
  - out_a_* = in_a_*[sel]; out_a_valid = |in_a_valid; in_a_ready[sel] = out_a_ready; all other in_a_ready = 0.
  - Arbitration adds zero cycles of latency (combinational path).
  - Valid, no ready: register grant=sel and go to LOCKED with beats_left = beats. This keeps out_a_* stable, as TL requires.
  - Fire of a 1-beat message: stay IDLE; rr_ptr = sel+1 mod NUM_REQ.
  - Fire of a multi-beat message: go to LOCKED with grant=sel, beats_left = beats-1.
- LOCKED:
  - Mux fixed to grant; only in_a_ready[grant] may be 1.
  - Each fire decrements beats_left.
  - Fire with beats_left==1: go to IDLE; rr_ptr = grant+1 mod NUM_REQ.
  - A grant requester that drops valid mid-burst is illegal upstream: the arbiter holds the lock and sets no flag.
- D routing (purely combinational):
  - t = out_d_source[top IDX_WD bits].
  - in_d_valid[t] = out_d_valid; out_d_ready = in_d_ready[t].
  - t >= NUM_REQ: out_d_ready=1 (beat dropped) and route_err is set, sticky until reset.
  - D is independent of A state. Simultaneous A and D fires are allowed every cycle.
- No A→D combinational loop: in_a_ready depends only on out_a_ready and the valids.

Decomposition:
- Package tl_test_pkg holds:
  - TL opcode constants (A: PutFullData=0, PutPartialData=1, ArithmeticData=2, LogicalData=3, Get=4, Intent=5, AcquireBlock=6, AcquirePerm=7).
  - Function a_has_data(opcode).
  - Function tl_beats(size, opcode, DATA_WD).
- One sub-module, tl_rr_picker: NUM_REQ-bit request vector plus rr_ptr in; one-hot select plus index out; purely combinational.

Test Plan:
- Reset mid-burst: reset_n=0 during beat 2/4 → outputs 0 at once; after release, rr_ptr=0 and the first requester found from index 0 is served, with no stale lock.
- Round-robin: all 4 requesters issue continuous Get with out_a_ready=1 → out_a_source tags go 0,1,2,3,0,… one message per cycle.
- Burst lock: req1 sends PutFullData size=7 (4 beats) while req0/req2 are valid → 4 consecutive req1 beats; then req2 is granted, then req0.
- Backpressure hold: req3 valid, out_a_ready=0 for 5 cycles, req0 raises valid at cycle 2 → out_a_* stay req3's values until the fire.
- D routing: out_d_source={2'd2,8'h5A} → only in_d_valid[2]=1, in_d_source=8'h5A, out_d_ready follows in_d_ready[2].
- Bad tag: NUM_REQ=3, out_d_source tag=3 → out_d_ready=1, no in_d_valid, route_err=1 and held until reset.
